// File: rtl/controle_multiciclo.sv
// -----------------------------------------------------------------------------
// controle_multiciclo
// Main control FSM for a multicycle MIPS datapath. Each instruction takes
// 3-5 cycles, plus one extra cycle for every cycle the memory holds
// mem_pronta low. All control outputs are decoded from the current state.
// Unknown opcodes pulse erro_opcode and go back to fetch.
//
// Memory handshake: MemRead / MemWrite are requests. Once raised, a request
// stays high, with the address held by IorD, until the memory returns
// mem_pronta=1 in that same cycle. The FSM leaves the access state only on
// the cycle where mem_pronta=1 is seen. The IR and PC are loaded during fetch
// only on that completing cycle.
// -----------------------------------------------------------------------------
module controle_multiciclo (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_pronta,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] Op_ALU,
    output logic [1:0] PCSource,
    output logic       erro_opcode,
    output logic [3:0] estado
);

    // Opcodes understood by the controller
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    // State codes, also visible on estado
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC      = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;

    // ALUSrcB selections
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Op_ALU codes for controle_ALU
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // PCSource selections
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [5:0] op_reg;
    logic       opcode_known;

    // Opcode recognised at decode time
    always_comb begin
        opcode_known = 1'b0;
        case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opcode_known = 1'b1;
            default:                                   opcode_known = 1'b0;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Opcode captured in DECODE so MEM_ADDR can tell LW from SW even if the
    // opcode input moves afterwards
    always_ff @(posedge clock) begin
        if (reset) begin
            op_reg <= 6'h00;
        end else if (state == S_DECODE) begin
            op_reg <= opcode;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: begin
                next_state = mem_pronta ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_R:         next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDI_EXEC;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (op_reg == OP_LW) begin
                    next_state = S_MEM_READ;
                end else if (op_reg == OP_SW) begin
                    next_state = S_MEM_WRITE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEM_READ: begin
                next_state = mem_pronta ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB:    next_state = S_FETCH;
            S_MEM_WRITE: begin
                next_state = mem_pronta ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC:      next_state = S_R_WB;
            S_R_WB:      next_state = S_FETCH;
            S_BRANCH:    next_state = S_FETCH;
            S_JUMP:      next_state = S_FETCH;
            S_ADDI_EXEC: next_state = S_ADDI_WB;
            S_ADDI_WB:   next_state = S_FETCH;
            default:     next_state = S_FETCH;
        endcase
    end

    // Control outputs decoded from state; all forced low while reset is high
    // so an aborted instruction cannot write PC, IR or the register file
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        Op_ALU      = ALU_ADD;
        PCSource    = PC_ALU;
        erro_opcode = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    // PC+4 computed every cycle, committed only with the IR
                    MemRead  = 1'b1;
                    IorD     = 1'b0;
                    ALUSrcA  = 1'b0;
                    ALUSrcB  = SRCB_FOUR;
                    Op_ALU   = ALU_ADD;
                    PCSource = PC_ALU;
                    IRWrite  = mem_pronta;
                    PCWrite  = mem_pronta;
                end
                S_DECODE: begin
                    // Speculative branch target into ALUOut
                    ALUSrcA     = 1'b0;
                    ALUSrcB     = SRCB_IMM_SH;
                    Op_ALU      = ALU_ADD;
                    erro_opcode = !opcode_known;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    Op_ALU  = ALU_ADD;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    RegDst   = 1'b0;
                end
                S_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_REG;
                    Op_ALU  = ALU_FUNCT;
                end
                S_R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    MemtoReg = 1'b0;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = SRCB_REG;
                    Op_ALU      = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PC_ALUOUT;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PC_JUMP;
                end
                S_ADDI_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    Op_ALU  = ALU_ADD;
                end
                S_ADDI_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Debug view of the state, blanked during reset like every other output
    always_comb begin
        estado = reset ? S_FETCH : state;
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_controle_multiciclo
// Table of {reset, opcode, mem_pronta, expected outputs} steps applied one per
// clock, plus a store sequence with random memory wait lengths.
// -----------------------------------------------------------------------------
module tb_controle_multiciclo;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_pronta;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, erro_opcode;
    logic [1:0] ALUSrcB, Op_ALU, PCSource;
    logic [3:0] estado;

    controle_multiciclo dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .mem_pronta  (mem_pronta),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .Op_ALU      (Op_ALU),
        .PCSource    (PCSource),
        .erro_opcode (erro_opcode),
        .estado      (estado)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-bit flag positions, OR-ed together to build expectations
    localparam logic [9:0] B_PCW  = 10'b10_0000_0000;
    localparam logic [9:0] B_PCWC = 10'b01_0000_0000;
    localparam logic [9:0] B_IORD = 10'b00_1000_0000;
    localparam logic [9:0] B_MR   = 10'b00_0100_0000;
    localparam logic [9:0] B_MW   = 10'b00_0010_0000;
    localparam logic [9:0] B_IRW  = 10'b00_0001_0000;
    localparam logic [9:0] B_MTR  = 10'b00_0000_1000;
    localparam logic [9:0] B_RD   = 10'b00_0000_0100;
    localparam logic [9:0] B_RW   = 10'b00_0000_0010;
    localparam logic [9:0] B_ASA  = 10'b00_0000_0001;

    function automatic logic [20:0] pk(input logic [3:0] st, input logic [9:0] b,
                                       input logic [1:0] asb, input logic [1:0] op,
                                       input logic [1:0] pcs, input logic err);
        return {st, b, asb, op, pcs, err};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mp;
        logic [20:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[80];
    int          nv;
    logic [20:0] exp_q[$];
    string       name_q[$];
    int          passed;
    int          total;

    logic [20:0] e_rst, e_fw, e_fg, e_dec, e_derr, e_ma, e_mr, e_mwb, e_mw;
    logic [20:0] e_ex, e_rwb, e_br, e_j, e_ae, e_aw;

    task automatic add(input logic r, input logic [5:0] op, input logic mp,
                       input logic [20:0] e, input string nm);
        vecs[nv].rst  = r;
        vecs[nv].op   = op;
        vecs[nv].mp   = mp;
        vecs[nv].exp  = e;
        vecs[nv].name = nm;
        nv++;
    endtask

    // Pop one expectation and compare it with the outputs now on the DUT
    task automatic check_outputs();
        logic [20:0] got;
        logic [20:0] e;
        string       nm;
        got = {estado, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, Op_ALU, PCSource, erro_opcode};
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (got === e) passed++;
        else $display("FAIL %s: got %h required %h (estado %0d vs %0d)", nm, got, e, got[20:17], e[20:17]);
        total++;
        if (!(MemRead && MemWrite) && !(RegWrite && PCWrite)) passed++;
        else $display("FAIL %s_excl: MemRead=%b MemWrite=%b RegWrite=%b PCWrite=%b required no overlap",
                      nm, MemRead, MemWrite, RegWrite, PCWrite);
    endtask

    // Drive one cycle of inputs, then check outputs before the next rising edge
    task automatic step(input logic r, input logic [5:0] op, input logic mp,
                        input logic [20:0] e, input string nm);
        @(negedge clock);
        reset      = r;
        opcode     = op;
        mem_pronta = mp;
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
        check_outputs();
    endtask

    initial begin
        int waits;
        reset      = 1'b1;
        opcode     = 6'h00;
        mem_pronta = 1'b0;
        nv         = 0;
        passed     = 0;
        total      = 0;

        e_rst  = 21'd0;
        e_fw   = pk(4'd0,  B_MR,               2'b01, 2'b00, 2'b00, 1'b0);
        e_fg   = pk(4'd0,  B_PCW | B_MR | B_IRW, 2'b01, 2'b00, 2'b00, 1'b0);
        e_dec  = pk(4'd1,  10'd0,              2'b11, 2'b00, 2'b00, 1'b0);
        e_derr = pk(4'd1,  10'd0,              2'b11, 2'b00, 2'b00, 1'b1);
        e_ma   = pk(4'd2,  B_ASA,              2'b10, 2'b00, 2'b00, 1'b0);
        e_mr   = pk(4'd3,  B_MR | B_IORD,      2'b00, 2'b00, 2'b00, 1'b0);
        e_mwb  = pk(4'd4,  B_RW | B_MTR,       2'b00, 2'b00, 2'b00, 1'b0);
        e_mw   = pk(4'd5,  B_MW | B_IORD,      2'b00, 2'b00, 2'b00, 1'b0);
        e_ex   = pk(4'd6,  B_ASA,              2'b00, 2'b10, 2'b00, 1'b0);
        e_rwb  = pk(4'd7,  B_RW | B_RD,        2'b00, 2'b00, 2'b00, 1'b0);
        e_br   = pk(4'd8,  B_ASA | B_PCWC,     2'b00, 2'b01, 2'b01, 1'b0);
        e_j    = pk(4'd9,  B_PCW,              2'b00, 2'b00, 2'b10, 1'b0);
        e_ae   = pk(4'd10, B_ASA,              2'b10, 2'b00, 2'b00, 1'b0);
        e_aw   = pk(4'd11, B_RW,               2'b00, 2'b00, 2'b00, 1'b0);

        // T1 reset two cycles, then first free fetch cycle with memory busy
        add(1, 6'h00, 1, e_rst, "reset_0");
        add(1, 6'h00, 1, e_rst, "reset_1");
        add(0, 6'h00, 0, e_fw,  "fetch_wait");
        // T2 R-type
        add(0, 6'h00, 1, e_fg,  "r_fetch");
        add(0, 6'h00, 0, e_dec, "r_decode");
        add(0, 6'h2B, 0, e_ex,  "r_exec");
        add(0, 6'h3F, 0, e_rwb, "r_wb");
        // T3 LW with three busy cycles; opcode changes after DECODE are ignored
        add(0, 6'h3F, 1, e_fg,  "lw_fetch");
        add(0, 6'h23, 1, e_dec, "lw_decode");
        add(0, 6'h2B, 1, e_ma,  "lw_addr");
        add(0, 6'h2B, 0, e_mr,  "lw_read_w0");
        add(0, 6'h00, 0, e_mr,  "lw_read_w1");
        add(0, 6'h04, 0, e_mr,  "lw_read_w2");
        add(0, 6'h02, 1, e_mr,  "lw_read_done");
        add(0, 6'h2B, 0, e_mwb, "lw_wb");
        // SW without wait
        add(0, 6'h00, 1, e_fg,  "sw_fetch");
        add(0, 6'h2B, 1, e_dec, "sw_decode");
        add(0, 6'h23, 1, e_ma,  "sw_addr");
        add(0, 6'h23, 1, e_mw,  "sw_write");
        // T4 BEQ
        add(0, 6'h00, 1, e_fg,  "beq_fetch");
        add(0, 6'h04, 1, e_dec, "beq_decode");
        add(0, 6'h00, 1, e_br,  "beq_branch");
        // J
        add(0, 6'h00, 1, e_fg,  "j_fetch");
        add(0, 6'h02, 1, e_dec, "j_decode");
        add(0, 6'h00, 1, e_j,   "j_jump");
        // ADDI
        add(0, 6'h00, 1, e_fg,  "addi_fetch");
        add(0, 6'h08, 1, e_dec, "addi_decode");
        add(0, 6'h00, 1, e_ae,  "addi_exec");
        add(0, 6'h00, 1, e_aw,  "addi_wb");
        // T5 unknown opcode: pulse in DECODE only, then back to fetch
        add(0, 6'h00, 1, e_fg,   "bad_fetch");
        add(0, 6'h3F, 1, e_derr, "bad_decode");
        add(0, 6'h3F, 0, e_fw,   "bad_refetch");
        // T6 reset during LW memory wait
        add(0, 6'h00, 1, e_fg,  "rst_lw_fetch");
        add(0, 6'h23, 1, e_dec, "rst_lw_decode");
        add(0, 6'h23, 1, e_ma,  "rst_lw_addr");
        add(0, 6'h23, 0, e_mr,  "rst_lw_read");
        add(1, 6'h23, 1, e_rst, "rst_lw_reset");
        add(0, 6'h23, 0, e_fw,  "rst_lw_after");
        // Reset on a completing fetch must not load IR/PC
        add(0, 6'h00, 1, e_fg,  "rst_fetch_pre");
        add(0, 6'h00, 1, e_dec, "rst_fetch_dec");
        add(0, 6'h00, 1, e_ex,  "rst_fetch_exec");
        add(1, 6'h00, 1, e_rst, "rst_in_exec");
        add(1, 6'h00, 1, e_rst, "rst_fetch_ready");
        add(0, 6'h00, 0, e_fw,  "rst_fetch_after");

        for (int i = 0; i < nv; i++) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].mp, vecs[i].exp, vecs[i].name);
        end

        // Stores and loads with random wait lengths on both fetch and data access
        for (int k = 0; k < 4; k++) begin
            waits = $urandom_range(0, 4);
            for (int w = 0; w < waits; w++) step(0, 6'h00, 0, e_fw, "rnd_fetch_wait");
            step(0, 6'h00, 1, e_fg, "rnd_fetch");
            step(0, (k[0] ? 6'h23 : 6'h2B), 1, e_dec, "rnd_decode");
            step(0, 6'h00, 1, e_ma, "rnd_addr");
            waits = $urandom_range(0, 5);
            for (int w = 0; w < waits; w++) step(0, 6'h00, 0, (k[0] ? e_mr : e_mw), "rnd_mem_wait");
            step(0, 6'h00, 1, (k[0] ? e_mr : e_mw), "rnd_mem_done");
            if (k[0]) step(0, 6'h00, 1, e_mwb, "rnd_lw_wb");
        end
        step(0, 6'h00, 0, e_fw, "rnd_end_fetch");

        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
